i2c_slave_rx_tx: RTL
====================

Name: i2c_slave_rx_tx

Overview:
I2C target (responder) for the bus driven by our I2C master. It monitors SCL/SDA, detects START/STOP, matches a 7-bit address, ACKs, then either receives write bytes or transmits read bytes. SDA is open-drain: the block only ever pulls low. Sits on the peripheral side; the byte interface connects to a register file or FIFO.

Parameters:
DEV_ADDR, 7'h50, 7-bit target address compared against the first byte after START.
SYNC_STAGES, 2, flops in the SCL/SDA input synchronizers (min 2).

Ports:
clk  input  1  system clock; must be >= 8x SCL frequency.
rst  input  1  synchronous, active-high reset.
scl_in  input  1  bus SCL, asynchronous.
sda_in  input  1  bus SDA, asynchronous (resolved wire value).
sda_oe  output  1  1 = pull SDA low; 0 = release.
rx_data  output  8  last received write byte, MSB first on bus.
rx_valid  output  1  1-clk pulse; rx_data updated the same cycle.
tx_data  input  8  byte to send on read; sampled on tx_load.
tx_load  output  1  1-clk pulse; tx_data captured this cycle.
busy  output  1  1 from address match until STOP, NACK or mismatch.
start_det  output  1  1-clk pulse on START or repeated START.
stop_det  output  1  1-clk pulse on STOP.

Behaviour:
- Reset values: sda_oe=0, rx_data=0, rx_valid=0, tx_load=0, busy=0, start_det=0, stop_det=0. State is IDLE and bit counter is 0.
- Input path: SYNC_STAGES flops, then 1 history flop per line. Edges are derived from the synced values only.
  - scl_rise/scl_fall: synced SCL transitions.
  - START: synced SDA falls while synced SCL=1.
  - STOP: synced SDA rises while synced SCL=1.
- Bit timing:
  - Data is sampled on scl_rise.
  - sda_oe changes only on scl_fall, plus a forced release on STOP, START or rst.
  - Bit counter is 0..7 and wraps to 0 after the ACK slot.
- States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT.
  - IDLE: wait for START. Go to ADDR with counter=0.
  - ADDR: shift 8 bits in (7 address + R/W).
    - After the 8th bit, if addr[7:1]==DEV_ADDR: go to ADDR_ACK and set busy=1.
    - Otherwise go to WAIT with sda_oe held 0.
  - ADDR_ACK: on the next scl_fall, sda_oe=1. Hold through the 9th SCL high. On the following scl_fall:
    - R/W=0: sda_oe=0, go to RX.
    - R/W=1: pulse tx_load, load shift register from tx_data, drive bit7 (sda_oe=~bit), go to TX.
  - RX: shift 8 bits. On the 8th scl_rise, rx_data<=byte and pulse rx_valid. Go to RX_ACK; sda_oe=1 on the next scl_fall, released on the scl_fall after that. Return to RX.
  - TX: on each scl_fall drive the next bit (sda_oe=~bit). After the 8th bit's scl_fall, sda_oe=0 and go to TX_ACK.
  - TX_ACK: sample master ACK on scl_rise.
    - SDA=0 (ACK): on the next scl_fall, pulse tx_load, load the next byte, drive its bit7, go to TX.
    - SDA=1 (NACK): busy=0, go to WAIT with sda_oe=0.
  - WAIT: ignore SCL. Leave only on START or STOP.
- Global conditions (priority rst > STOP > START > bit logic):
  - START in any state: pulse start_det, sda_oe=0, counter=0, busy=0, go to ADDR.
  - STOP in any state: pulse stop_det, sda_oe=0, busy=0, go to IDLE. A partial byte is discarded with no rx_valid.
  - rst mid-transfer: immediately return to reset values. The next bus activity is ignored until a START.
- General call (address 0) is not acknowledged. There is no clock stretching.
- Latency: bus edge to internal event is SYNC_STAGES+1 clk.

Test Plan:
1. Write: START, 0xA0, 0x3C, 0x81, STOP with DEV_ADDR=0x50 -> ACK (sda_oe=1) in slots 9, 18 and 27. rx_valid pulses twice with rx_data=0x3C then 0x81. busy drops at STOP; one stop_det pulse.
2. Address mismatch: START, 0xA2, 0x55, STOP -> sda_oe stays 0 throughout, no rx_valid, busy stays 0, one stop_det pulse.
3. Read: START, 0xA1; tx_data=0xC5 then 0x5A; master ACKs byte 1, NACKs byte 2; STOP -> bus carries 0xC5 then 0x5A MSB first. tx_load pulses twice, sda_oe=0 after the NACK, state is IDLE after STOP.
4. Repeated START: START, 0xA0, 0x11, Sr, 0xA1, read one byte, NACK, STOP -> rx_data=0x11, start_det pulses twice, direction switches to TX after the second address ACK.
5. Abort: STOP after 4 bits of a write data byte -> no rx_valid, sda_oe=0, state IDLE. A following full write of 0x77 is received correctly.
6. Reset mid-transfer: rst=1 for 1 clk while driving read bit 3 with sda_oe=1 -> next clk sda_oe=0 and busy=0. The block ignores SCL until the next START, then ACKs 0xA0 normally.

Source files
------------

// File: rtl/i2c_slave_rx_tx.sv
// I2C target (responder) with a 7-bit address match, write-byte receive and
// read-byte transmit. SDA is open-drain: sda_oe=1 pulls the line low and
// sda_oe=0 releases it. SCL/SDA are synchronized into clk. All bus decisions
// are made from the synchronized copies and their one-cycle history.
module i2c_slave_rx_tx #(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    RX       = 3'd3,
    RX_ACK   = 3'd4,
    TX       = 3'd5,
    TX_ACK   = 3'd6,
    WAIT     = 3'd7
  } state_t;

  // Input synchronizers and one-cycle history
  logic [SYNC_STAGES-1:0] scl_sync_r;
  logic [SYNC_STAGES-1:0] sda_sync_r;
  logic                   scl_d_r;
  logic                   sda_d_r;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_rise_s;
  logic                   scl_fall_s;
  logic                   start_s;
  logic                   stop_s;

  // Protocol state
  state_t     state_r,    state_n;
  logic [2:0] bit_cnt_r,  bit_cnt_n;
  logic [6:0] shift_r,    shift_n;
  logic       rw_r,       rw_n;
  logic       phase_r,    phase_n;
  logic       sda_oe_r,   sda_oe_n;
  logic       busy_r,     busy_n;
  logic [7:0] rx_data_r,  rx_data_n;
  logic       rx_valid_r, rx_valid_n;
  logic       tx_load_r,  tx_load_n;
  logic       start_r,    start_n;
  logic       stop_r,     stop_n;
  logic [7:0] byte_in_s;

  // Synchronizer chains run freely so that a reset never manufactures a bus edge
  always_ff @(posedge clk) begin
    scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_in};
    sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_in};
  end

  assign scl_s = scl_sync_r[SYNC_STAGES-1];
  assign sda_s = sda_sync_r[SYNC_STAGES-1];

  // History flops; on reset they track the synced lines so no edge is seen
  always_ff @(posedge clk) begin
    scl_d_r <= scl_s;
    sda_d_r <= sda_s;
  end

  assign scl_rise_s = scl_s & ~scl_d_r;
  assign scl_fall_s = ~scl_s & scl_d_r;
  assign start_s    = scl_s & scl_d_r & sda_d_r & ~sda_s;
  assign stop_s     = scl_s & scl_d_r & ~sda_d_r & sda_s;

  // Byte formed by shifting in the currently sampled SDA bit, MSB first
  assign byte_in_s = {shift_r, sda_s};

  // Next-state and output logic; STOP outranks START, which outranks bit logic
  always_comb begin
    state_n    = state_r;
    bit_cnt_n  = bit_cnt_r;
    shift_n    = shift_r;
    rw_n       = rw_r;
    phase_n    = phase_r;
    sda_oe_n   = sda_oe_r;
    busy_n     = busy_r;
    rx_data_n  = rx_data_r;
    rx_valid_n = 1'b0;
    tx_load_n  = 1'b0;
    start_n    = 1'b0;
    stop_n     = 1'b0;

    if (stop_s) begin
      stop_n    = 1'b1;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
      bit_cnt_n = 3'd0;
      phase_n   = 1'b0;
      state_n   = IDLE;
    end else if (start_s) begin
      start_n   = 1'b1;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
      bit_cnt_n = 3'd0;
      phase_n   = 1'b0;
      state_n   = ADDR;
    end else begin
      case (state_r)
        IDLE: begin
          state_n = IDLE;
        end

        ADDR: begin
          if (scl_rise_s) begin
            shift_n = byte_in_s[6:0];
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_n = 3'd0;
              phase_n   = 1'b0;
              if (byte_in_s[7:1] == DEV_ADDR) begin
                rw_n    = byte_in_s[0];
                busy_n  = 1'b1;
                state_n = ADDR_ACK;
              end else begin
                sda_oe_n = 1'b0;
                state_n  = WAIT;
              end
            end else begin
              bit_cnt_n = bit_cnt_r + 3'd1;
            end
          end else begin
            state_n = ADDR;
          end
        end

        // phase 0: drive ACK on first fall; phase 1: end of ACK slot
        ADDR_ACK: begin
          if (scl_fall_s) begin
            if (!phase_r) begin
              sda_oe_n = 1'b1;
              phase_n  = 1'b1;
            end else begin
              phase_n   = 1'b0;
              bit_cnt_n = 3'd0;
              if (rw_r) begin
                tx_load_n = 1'b1;
                shift_n   = tx_data[6:0];
                sda_oe_n  = ~tx_data[7];
                state_n   = TX;
              end else begin
                sda_oe_n = 1'b0;
                state_n  = RX;
              end
            end
          end else begin
            state_n = ADDR_ACK;
          end
        end

        RX: begin
          if (scl_rise_s) begin
            shift_n = byte_in_s[6:0];
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_n  = 3'd0;
              rx_data_n  = byte_in_s;
              rx_valid_n = 1'b1;
              phase_n    = 1'b0;
              state_n    = RX_ACK;
            end else begin
              bit_cnt_n = bit_cnt_r + 3'd1;
            end
          end else begin
            state_n = RX;
          end
        end

        RX_ACK: begin
          if (scl_fall_s) begin
            if (!phase_r) begin
              sda_oe_n = 1'b1;
              phase_n  = 1'b1;
            end else begin
              sda_oe_n = 1'b0;
              phase_n  = 1'b0;
              state_n  = RX;
            end
          end else begin
            state_n = RX_ACK;
          end
        end

        // bit7 is already on the bus on entry; each fall presents the next bit
        TX: begin
          if (scl_fall_s) begin
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_n = 3'd0;
              sda_oe_n  = 1'b0;
              phase_n   = 1'b0;
              state_n   = TX_ACK;
            end else begin
              sda_oe_n  = ~shift_r[6];
              shift_n   = {shift_r[5:0], 1'b0};
              bit_cnt_n = bit_cnt_r + 3'd1;
            end
          end else begin
            state_n = TX;
          end
        end

        // phase 1 means the master ACKed and the next byte goes out on the fall
        TX_ACK: begin
          if (scl_rise_s) begin
            if (sda_s) begin
              busy_n   = 1'b0;
              sda_oe_n = 1'b0;
              state_n  = WAIT;
            end else begin
              phase_n = 1'b1;
            end
          end else if (scl_fall_s && phase_r) begin
            phase_n   = 1'b0;
            bit_cnt_n = 3'd0;
            tx_load_n = 1'b1;
            shift_n   = tx_data[6:0];
            sda_oe_n  = ~tx_data[7];
            state_n   = TX;
          end else begin
            state_n = TX_ACK;
          end
        end

        WAIT: begin
          state_n = WAIT;
        end

        default: begin
          sda_oe_n = 1'b0;
          busy_n   = 1'b0;
          state_n  = IDLE;
        end
      endcase
    end
  end

  // State and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 7'd0;
      rw_r       <= 1'b0;
      phase_r    <= 1'b0;
      sda_oe_r   <= 1'b0;
      busy_r     <= 1'b0;
      rx_data_r  <= 8'd0;
      rx_valid_r <= 1'b0;
      tx_load_r  <= 1'b0;
      start_r    <= 1'b0;
      stop_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      bit_cnt_r  <= bit_cnt_n;
      shift_r    <= shift_n;
      rw_r       <= rw_n;
      phase_r    <= phase_n;
      sda_oe_r   <= sda_oe_n;
      busy_r     <= busy_n;
      rx_data_r  <= rx_data_n;
      rx_valid_r <= rx_valid_n;
      tx_load_r  <= tx_load_n;
      start_r    <= start_n;
      stop_r     <= stop_n;
    end
  end

  assign sda_oe    = sda_oe_r;
  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign tx_load   = tx_load_r;
  assign busy      = busy_r;
  assign start_det = start_r;
  assign stop_det  = stop_r;

endmodule
